quadrature_decoder: RTL and testbench
=====================================

Name: quadrature_decoder

Overview:
- Receive-side companion to the two-phase square-wave generator.
- Samples the two 90°-offset square waves (in1, in2) and tracks their relative phase.
- Produces a signed-direction step pulse, a wrapping position count and a sticky illegal-transition flag.
- Sits on the sensing end of any link driven by the two-phase generator: encoder inputs, loopback test, phase checking.

Parameters:
- CNT_WIDTH, 8: width of position counter; wraps modulo 2^CNT_WIDTH.
- SYNC_STAGES, 2: flip-flop synchronizer depth on in1/in2; legal range 2..4.
- FILT_CYCLES, 3: stability window in clk cycles; used only when QD_GLITCH_FILTER_EN is defined; legal range 2..15.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  asynchronous, active-low reset; assertion (0) clears all state immediately; release is synchronous to clk.
- in1  input  1  phase-A input, asynchronous to clk.
- in2  input  1  phase-B input, asynchronous to clk.
- clr  input  1  synchronous clear of count and err; active-high, single cycle.
- count  output  CNT_WIDTH  position count, two's-complement wrap.
- dir  output  1  direction of last valid step: 1 = forward, 0 = reverse.
- step  output  1  one-cycle pulse per valid step.
- err  output  1  sticky illegal-transition flag.

Behaviour:
- Reset (reset=0) forces count=0, dir=0, step=0, err=0, synchronizer=0, prev=00, state=INIT. All outputs are registered.
- Synchronizer: in1/in2 each pass through SYNC_STAGES flops; s = {s1,s2} is the synchronized pair.
- State INIT: after reset release, waits SYNC_STAGES cycles so the synchronizer flushes. On the next edge it loads prev <= s with no step and no count change, then moves to RUN.
- State RUN: each edge compares s with prev, then sets prev <= s.
  - Forward sequence {in1,in2}: 10 -> 11 -> 01 -> 00 -> 10. This matches the generator's counter 0,1,2,3 order.
  - Forward transition: count <= count+1, dir <= 1, step <= 1.
  - Reverse transition (the forward sequence read backwards): count <= count-1, dir <= 0, step <= 1.
  - s == prev: step <= 0; count and dir hold.
  - Both bits changed (10<->01, 11<->00): err <= 1, step <= 0, count and dir hold. prev still updates to s so decoding resynchronizes.
- Latency: an input change sampled at edge N shows on count/step/dir after edge N+SYNC_STAGES.
- step is high for exactly one cycle per transition. Back-to-back steps on consecutive cycles give consecutive step pulses.
- Wrap-around: all-ones + forward gives 0; 0 + reverse gives all-ones. No saturation, no flag.
- clr:
  - clr=1 on an edge sets count <= 0 and err <= 0. prev still updates and dir updates normally.
  - step still pulses if a transition occurs that cycle, but count is 0 that cycle: clr wins over increment/decrement.
  - A new illegal transition in the same cycle as clr sets err=1: error wins over clear for err only.
- Reset asserted mid-operation: all state clears immediately, asynchronously. On release the block re-enters INIT; no spurious step is generated from the prev=00 reset value.

Optional Feature:
- Macro: QD_GLITCH_FILTER_EN.
- Defined:
  - A stability filter sits between the synchronizer and the decoder.
  - A new s value is passed to the decoder only after it has held constant for FILT_CYCLES consecutive cycles.
  - Shorter pulses are discarded entirely.
  - Adds FILT_CYCLES cycles to latency.
  - INIT additionally waits FILT_CYCLES cycles before loading prev.
- Not defined: the filter is absent; the synchronizer output feeds the decoder directly; FILT_CYCLES is ignored.

Test Plan (CNT_WIDTH=8, SYNC_STAGES=2; each input level held 4 cycles unless stated):
- Reset, then drive 8 forward transitions from 10 -> count=8, dir=1, exactly 8 step pulses, err=0. First step appears 2 edges after the first input change.
- From count=0, drive 3 reverse transitions (10->00->01->11) -> count=253 (0xFD), dir=0, 3 step pulses.
- Force 10->01 in one edge -> err=1, step=0, count unchanged. Then pulse clr -> err=0, count=0.
- Assert clr in the same cycle a forward step reaches the decoder (count=5) -> count=0, step=1, dir=1. Next forward step -> count=1.
- At count=5, assert reset=0 mid-cycle -> count/dir/step/err read 0 before the next edge. Release with inputs at 11 -> no step, count stays 0 until the first real transition.
- One-cycle glitch on in1 (10->00->10):
  - With QD_GLITCH_FILTER_EN: no step, count unchanged.
  - Without it: one reverse then one forward step; count returns to its original value; 2 step pulses.

Source files
------------

// File: rtl/quadrature_decoder.sv
// Quadrature decoder: synchronizes two 90-degree-offset square waves and tracks
// position, direction and illegal transitions. Optional stability filter via QD_GLITCH_FILTER_EN.
module quadrature_decoder #(
    parameter int CNT_WIDTH   = 8,
    parameter int SYNC_STAGES = 2,
    parameter int FILT_CYCLES = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in1,
    input  logic                 in2,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 dir,
    output logic                 step,
    output logic                 err
);

`ifdef QD_GLITCH_FILTER_EN
    localparam bit FILT_ON = 1'b1;
`else
    localparam bit FILT_ON = 1'b0;
`endif
    localparam int INIT_WAIT = SYNC_STAGES + (FILT_ON ? FILT_CYCLES : 0);
    localparam int IW        = $clog2(INIT_WAIT + 1);
    localparam logic [IW-1:0] INIT_WAIT_V = IW'(INIT_WAIT);

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    state_e                 state_q, state_d;
    logic [IW-1:0]          init_cnt_q, init_cnt_d;
    logic [SYNC_STAGES-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [1:0]             prev_q, prev_d;
    logic [CNT_WIDTH-1:0]   count_q, count_d;
    logic                   dir_q, dir_d, step_q, step_d, err_q, err_d;
    logic [1:0]             s_sync, dec_in, delta;
    logic                   init_done, load_prev, fwd, rev, bad;

    // Position within the forward cycle 10 -> 11 -> 01 -> 00.
    function automatic logic [1:0] phase(input logic [1:0] ab);
        case (ab)
            2'b10:   phase = 2'd0;
            2'b11:   phase = 2'd1;
            2'b01:   phase = 2'd2;
            default: phase = 2'd3;
        endcase
    endfunction

    always_comb begin
        sync1_d = {sync1_q[SYNC_STAGES-2:0], in1};
        sync2_d = {sync2_q[SYNC_STAGES-2:0], in2};
    end
    assign s_sync = {sync1_q[SYNC_STAGES-1], sync2_q[SYNC_STAGES-1]};

`ifdef QD_GLITCH_FILTER_EN
    logic [1:0] cand_q, cand_d, filt_q, filt_d;
    logic [3:0] fcnt_q, fcnt_d;

    // A candidate value is forwarded only after FILT_CYCLES consecutive matching samples.
    always_comb begin
        cand_d = cand_q;
        filt_d = filt_q;
        fcnt_d = fcnt_q;
        if (s_sync != cand_q) begin
            cand_d = s_sync;
            fcnt_d = 4'd1;
        end else begin
            if (fcnt_q != 4'(FILT_CYCLES)) fcnt_d = fcnt_q + 4'd1;
            if (fcnt_q == 4'(FILT_CYCLES - 1)) filt_d = cand_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cand_q <= 2'b00;
            filt_q <= 2'b00;
            fcnt_q <= 4'd0;
        end else begin
            cand_q <= cand_d;
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end
    assign dec_in = filt_q;
`else
    assign dec_in = s_sync;
`endif

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_INIT;
            init_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
        end
    end

    assign init_done = (init_cnt_q == INIT_WAIT_V);

    // Next-state logic
    always_comb begin
        state_d    = state_q;
        init_cnt_d = init_cnt_q;
        if (state_q == ST_INIT) begin
            if (init_done) state_d = ST_RUN;
            else           init_cnt_d = init_cnt_q + 1'b1;
        end
    end

    // Output/decode logic
    always_comb begin
        delta     = phase(dec_in) - phase(prev_q);
        load_prev = (state_q == ST_INIT) && init_done;
        fwd       = (state_q == ST_RUN) && (delta == 2'd1);
        rev       = (state_q == ST_RUN) && (delta == 2'd3);
        bad       = (state_q == ST_RUN) && (delta == 2'd2);
    end

    always_comb begin
        prev_d  = (state_q == ST_RUN || load_prev) ? dec_in : prev_q;
        count_d = count_q;
        if (clr)      count_d = '0;
        else if (fwd) count_d = count_q + CNT_WIDTH'(1);
        else if (rev) count_d = count_q - CNT_WIDTH'(1);
        dir_d  = fwd ? 1'b1 : (rev ? 1'b0 : dir_q);
        step_d = fwd | rev;
        // A fresh illegal transition outranks a simultaneous clear.
        err_d  = bad ? 1'b1 : (clr ? 1'b0 : err_q);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q <= '0;
            sync2_q <= '0;
            prev_q  <= 2'b00;
            count_q <= '0;
            dir_q   <= 1'b0;
            step_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            sync1_q <= sync1_d;
            sync2_q <= sync2_d;
            prev_q  <= prev_d;
            count_q <= count_d;
            dir_q   <= dir_d;
            step_q  <= step_d;
            err_q   <= err_d;
        end
    end

    assign count = count_q;
    assign dir   = dir_q;
    assign step  = step_q;
    assign err   = err_q;

endmodule

// File: tb/tb_quadrature_decoder.sv
// Scoreboard bench for quadrature_decoder: each driven transition queues its
// expected count/dir; a monitor pops one entry per step pulse.
module tb_quadrature_decoder;
    logic       clk = 1'b0, reset = 1'b0, in1 = 1'b1, in2 = 1'b0, clr = 1'b0;
    logic [7:0] count;
    logic       dir, step, err;

`ifdef QD_GLITCH_FILTER_EN
    localparam int LAT = 2 + 3;
`else
    localparam int LAT = 2;
`endif

    typedef struct packed {logic [7:0] cnt; logic dir;} exp_t;
    exp_t sb[$];
    int   checks = 0, errors = 0;

    quadrature_decoder #(.CNT_WIDTH(8), .SYNC_STAGES(2), .FILT_CYCLES(3)) dut (
        .clk(clk), .reset(reset), .in1(in1), .in2(in2), .clr(clr),
        .count(count), .dir(dir), .step(step), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic a, input logic b, input bit push, input logic [7:0] c, input logic d);
        @(posedge clk); #1;
        in1 = a; in2 = b;
        if (push) sb.push_back('{cnt: c, dir: d});
        repeat (3) @(posedge clk);
    endtask

    task automatic settle();
        repeat (LAT + 3) @(posedge clk);
        #1;
    endtask

    task automatic pulse_clr();
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
    endtask

    initial begin
        fork
            forever begin
                exp_t e;
                @(negedge clk);
                if (reset && step) begin
                    if (sb.size() == 0) chk("unexpected_step", 1, 0);
                    else begin
                        e = sb.pop_front();
                        chk("step_count", int'(count), int'(e.cnt));
                        chk("step_dir", int'(dir), int'(e.dir));
                    end
                end
            end
            begin
                #200000;
                $display("FAIL watchdog: sim time limit reached, expected finish earlier");
                $fatal(1);
            end
        join_none

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_count", int'(count), 0);
        chk("rst_dir", int'(dir), 0);
        chk("rst_step", int'(step), 0);
        chk("rst_err", int'(err), 0);
        @(posedge clk); #1 reset = 1'b1;
        repeat (8) @(posedge clk);
        #1 chk("init_count", int'(count), 0);

        // First forward step and its latency
        @(posedge clk); #1;
        in1 = 1'b1; in2 = 1'b1;
        sb.push_back('{cnt: 8'd1, dir: 1'b1});
        repeat (LAT + 1) @(negedge clk);
        chk("first_step_early", int'(step), 0);
        @(negedge clk);
        chk("first_step_lat", int'(step), 1);

        drive(0, 1, 1, 8'd2, 1);
        drive(0, 0, 1, 8'd3, 1);
        drive(1, 0, 1, 8'd4, 1);
        drive(1, 1, 1, 8'd5, 1);
        drive(0, 1, 1, 8'd6, 1);
        drive(0, 0, 1, 8'd7, 1);
        drive(1, 0, 1, 8'd8, 1);
        settle();
        chk("fwd8_count", int'(count), 8);
        chk("fwd8_dir", int'(dir), 1);
        chk("fwd8_err", int'(err), 0);

        // Reverse from zero wraps down
        pulse_clr();
        settle();
        chk("clr_count", int'(count), 0);
        drive(0, 0, 1, 8'd255, 0);
        drive(0, 1, 1, 8'd254, 0);
        drive(1, 1, 1, 8'd253, 0);
        settle();
        chk("rev3_count", int'(count), 253);
        chk("rev3_dir", int'(dir), 0);

        // Illegal double-bit transition, then clear
        drive(1, 0, 1, 8'd252, 0);
        drive(0, 1, 0, 8'd0, 0);
        settle();
        chk("illegal_err", int'(err), 1);
        chk("illegal_count", int'(count), 252);
        chk("illegal_step", int'(step), 0);
        pulse_clr();
        settle();
        chk("clr_err", int'(err), 0);
        chk("clr_err_count", int'(count), 0);

        // clr collides with a forward step at count=5
        drive(0, 0, 1, 8'd1, 1);
        drive(1, 0, 1, 8'd2, 1);
        drive(1, 1, 1, 8'd3, 1);
        drive(0, 1, 1, 8'd4, 1);
        drive(0, 0, 1, 8'd5, 1);
        settle();
        chk("pre_clr_count", int'(count), 5);
        @(posedge clk); #1;
        in1 = 1'b1; in2 = 1'b0;
        sb.push_back('{cnt: 8'd0, dir: 1'b1});
        repeat (LAT) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        chk("clr_step_pulse", int'(step), 1);
        chk("clr_step_count", int'(count), 0);
        drive(1, 1, 1, 8'd1, 1);
        settle();
        chk("after_clr_count", int'(count), 1);

        // Asynchronous reset mid-cycle at count=5
        drive(0, 1, 1, 8'd2, 1);
        drive(0, 0, 1, 8'd3, 1);
        drive(1, 0, 1, 8'd4, 1);
        drive(1, 1, 1, 8'd5, 1);
        settle();
        chk("pre_rst_count", int'(count), 5);
        @(posedge clk); #3 reset = 1'b0;
        #1;
        chk("async_rst_count", int'(count), 0);
        chk("async_rst_dir", int'(dir), 0);
        chk("async_rst_step", int'(step), 0);
        chk("async_rst_err", int'(err), 0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        repeat (10) @(posedge clk);
        #1 chk("rerelease_count", int'(count), 0);
        drive(0, 1, 1, 8'd1, 1);
        settle();
        chk("post_rst_count", int'(count), 1);

        // One-cycle glitch on in1 while sitting at 10
        drive(0, 0, 1, 8'd2, 1);
        drive(1, 0, 1, 8'd3, 1);
        settle();
        @(posedge clk); #1 in1 = 1'b0;
`ifndef QD_GLITCH_FILTER_EN
        sb.push_back('{cnt: 8'd2, dir: 1'b0});
        sb.push_back('{cnt: 8'd3, dir: 1'b1});
`endif
        @(posedge clk); #1 in1 = 1'b1;
        repeat (LAT + 8) @(posedge clk);
        #1;
        chk("glitch_count", int'(count), 3);
        chk("sb_drain", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
